// File: rtl/shift_op_sequencer.sv
// Issue/sequencing stage in front of the ShiftLR shifter: accepts shift/rotate ops, runs one or two
// shifter passes, returns a tagged result. Optional performance counters under SHIFT_SEQ_PERF_EN.
module shift_op_sequencer #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    // Handshakes (both sides): a transfer happens on a rising clock edge where VALID and READY
    // are both high; VALID, once raised, holds its payload stable until that edge.
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IN_OP,
    input  logic [31:0]      IN_A,
    input  logic [4:0]       IN_S,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic [31:0]      SH_X,
    output logic [4:0]       SH_S,
    output logic             SH_LEFT,
    output logic             SH_LOG,
    input  logic [31:0]      SH_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_Z,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ERR
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [31:0]      PERF_OPS,
    output logic [31:0]      PERF_STALL
`endif
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_CAP1   = 3'd2,
        ST_CAP2   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;
    state_t dbg_state;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [4:0]  s_q;
    logic [31:0] part_q;

    logic in_legal;
    logic op_is_rot;
    logic accept;

    assign dbg_state = state_q;
    assign in_legal  = (IN_OP <= OP_ROR);
    assign op_is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);

    // {LEFT, LOG} for the first pass; SLL's LOG is a don't-care, driven as 1.
    function automatic logic [1:0] pass1_dir(input logic [2:0] op);
        logic [1:0] dir;
        dir = 2'b11;
        case (op)
            OP_SLL:  dir = 2'b11;
            OP_SRL:  dir = 2'b01;
            OP_SRA:  dir = 2'b00;
            OP_ROL:  dir = 2'b11;
            OP_ROR:  dir = 2'b01;
            default: dir = 2'b11;
        endcase
        return dir;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept  = 1'b1;
                    state_d = in_legal ? ST_ISSUE1 : ST_DONE;
                end
            end
            ST_ISSUE1: state_d = ST_CAP1;
            ST_CAP1:   state_d = op_is_rot ? ST_CAP2 : ST_DONE;
            ST_CAP2:   state_d = ST_DONE;
            ST_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // SH_* are registered: pass 1 is loaded on the accept edge so ShiftLR sees it throughout
    // ISSUE1; pass 2 is loaded on the ISSUE1->CAP1 edge so it is sampled at the end of CAP1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            s_q     <= 5'd0;
            part_q  <= 32'd0;
            SH_X    <= 32'd0;
            SH_S    <= 5'd0;
            SH_LEFT <= 1'b0;
            SH_LOG  <= 1'b0;
            OUT_Z   <= 32'd0;
            OUT_TAG <= '0;
            OUT_ERR <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= IN_OP;
                        a_q     <= IN_A;
                        s_q     <= IN_S;
                        OUT_TAG <= IN_TAG;
                        OUT_ERR <= !in_legal;
                        OUT_Z   <= 32'd0;
                        if (in_legal) begin
                            SH_X              <= IN_A;
                            SH_S              <= IN_S;
                            {SH_LEFT, SH_LOG} <= pass1_dir(IN_OP);
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (op_is_rot) begin
                        // Second pass goes the other way by (32-S) mod 32, always logical.
                        SH_X    <= a_q;
                        SH_S    <= 5'd0 - s_q;
                        SH_LEFT <= (op_q == OP_ROR);
                        SH_LOG  <= 1'b1;
                    end
                end
                ST_CAP1: begin
                    if (op_is_rot) begin
                        part_q <= SH_Z;
                    end else begin
                        OUT_Z <= SH_Z;
                    end
                end
                ST_CAP2: begin
                    OUT_Z <= part_q | SH_Z;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            PERF_OPS   <= 32'd0;
            PERF_STALL <= 32'd0;
        end else begin
            if (OUT_VALID && OUT_READY) begin
                PERF_OPS <= PERF_OPS + 32'd1;
            end
            if (OUT_VALID && !OUT_READY) begin
                PERF_STALL <= PERF_STALL + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed bench for shift_op_sequencer with a behavioural ShiftLR (1-cycle input register).
module tb_shift_op_sequencer;

    logic        clock;
    logic        reset_n;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  IN_OP;
    logic [31:0] IN_A;
    logic [4:0]  IN_S;
    logic [3:0]  IN_TAG;
    logic [31:0] SH_X;
    logic [4:0]  SH_S;
    logic        SH_LEFT;
    logic        SH_LOG;
    logic [31:0] SH_Z;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_Z;
    logic [3:0]  OUT_TAG;
    logic        OUT_ERR;
`ifdef SHIFT_SEQ_PERF_EN
    logic [31:0] PERF_OPS;
    logic [31:0] PERF_STALL;
`endif

    int checks = 0;
    int errors = 0;

    shift_op_sequencer #(.TAG_W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_OP     (IN_OP),
        .IN_A      (IN_A),
        .IN_S      (IN_S),
        .IN_TAG    (IN_TAG),
        .SH_X      (SH_X),
        .SH_S      (SH_S),
        .SH_LEFT   (SH_LEFT),
        .SH_LOG    (SH_LOG),
        .SH_Z      (SH_Z),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_Z     (OUT_Z),
        .OUT_TAG   (OUT_TAG),
        .OUT_ERR   (OUT_ERR)
`ifdef SHIFT_SEQ_PERF_EN
        ,
        .PERF_OPS  (PERF_OPS),
        .PERF_STALL(PERF_STALL)
`endif
    );

    // Clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ShiftLR model: registers its inputs every edge, Z is combinational from the registers
    logic [31:0] m_x;
    logic [4:0]  m_s;
    logic        m_left;
    logic        m_log;
    always @(posedge clock) begin
        m_x    <= SH_X;
        m_s    <= SH_S;
        m_left <= SH_LEFT;
        m_log  <= SH_LOG;
    end
    always_comb begin
        SH_Z = 32'd0;
        if (m_left)     SH_Z = m_x << m_s;
        else if (m_log) SH_Z = m_x >> m_s;
        else            SH_Z = $unsigned($signed(m_x) >>> m_s);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver: offer an op until accepted; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [4:0] s,
                        input logic [3:0] tag, input string name);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        IN_VALID = 1'b1;
        IN_OP    = op;
        IN_A     = a;
        IN_S     = s;
        IN_TAG   = tag;
        for (int i = 0; i < 20; i++) begin
            if (IN_READY) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1 IN_VALID = 1'b0;
        check({name, "_accept"}, 32'(ok), 32'd1);
    endtask

    // lat = clock edges after the accept edge until OUT_VALID is seen; -1 on timeout.
    task automatic wait_res(output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (OUT_VALID) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [4:0] s,
                          input logic [3:0] tag, input logic [31:0] exp_z, input logic exp_err,
                          input int exp_lat, input string name);
        int lat;
        send(op, a, s, tag, name);
        wait_res(lat);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_z"}, OUT_Z, exp_z);
        check({name, "_tag"}, 32'(OUT_TAG), 32'(tag));
        check({name, "_err"}, 32'(OUT_ERR), 32'(exp_err));
        check({name, "_inrdy_done"}, 32'(IN_READY), 32'd0);
        @(negedge clock);
        check({name, "_inrdy_after"}, 32'(IN_READY), 32'd1);
        check({name, "_valid_after"}, 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_z;
        logic [3:0]  held_tag;
        int          lat;
        int          seen;

        reset_n   = 1'b0;
        IN_VALID  = 1'b0;
        IN_OP     = 3'd0;
        IN_A      = 32'd0;
        IN_S      = 5'd0;
        IN_TAG    = 4'd0;
        OUT_READY = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_z", OUT_Z, 32'd0);
        check("rst_out_tag", 32'(OUT_TAG), 32'd0);
        check("rst_out_err", 32'(OUT_ERR), 32'd0);
        check("rst_sh", {SH_X[23:0], SH_S, 1'b0, SH_LEFT, SH_LOG}, 32'd0);
        reset_n = 1'b1;

        // Shifts: 2 edges after accept; rotates: 3
        run_op(3'b000, 32'h0000_0001, 5'd31, 4'h1, 32'h8000_0000, 1'b0, 2, "sll31");
        run_op(3'b010, 32'h8000_00F0, 5'd4,  4'h2, 32'hF800_000F, 1'b0, 2, "sra4");
        run_op(3'b001, 32'h8000_00F0, 5'd4,  4'h3, 32'h0800_000F, 1'b0, 2, "srl4");
        run_op(3'b010, 32'h7000_0000, 5'd31, 4'h4, 32'h0000_0000, 1'b0, 2, "sra_pos");
        run_op(3'b011, 32'h8000_0001, 5'd1,  4'h5, 32'h0000_0003, 1'b0, 3, "rol1");
        run_op(3'b100, 32'h0000_0001, 5'd1,  4'h6, 32'h8000_0000, 1'b0, 3, "ror1");
        run_op(3'b011, 32'h1234_5678, 5'd0,  4'h7, 32'h1234_5678, 1'b0, 3, "rol0");
        run_op(3'b100, 32'h1234_5678, 5'd8,  4'h8, 32'h7812_3456, 1'b0, 3, "ror8");
        // Illegal op: OUT_VALID already high in the cycle right after the accept edge
        run_op(3'b111, 32'hDEAD_BEEF, 5'd3,  4'hA, 32'h0000_0000, 1'b1, 0, "illegal");

        // Backpressure: five stalled cycles in DONE
        OUT_READY = 1'b0;
        send(3'b000, 32'h0000_00FF, 5'd8, 4'hC, "bp");
        wait_res(lat);
        check("bp_lat", 32'(lat), 32'd2);
        check("bp_z", OUT_Z, 32'h0000_FF00);
        held_z   = OUT_Z;
        held_tag = OUT_TAG;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("bp_hold_valid", 32'(OUT_VALID), 32'd1);
            check("bp_hold_z", OUT_Z, held_z);
            check("bp_hold_tag", 32'(OUT_TAG), 32'(held_tag));
            check("bp_hold_inrdy", 32'(IN_READY), 32'd0);
        end
        @(negedge clock);
        OUT_READY = 1'b1;
        @(negedge clock);
        check("bp_release_inrdy", 32'(IN_READY), 32'd1);
        check("bp_release_valid", 32'(OUT_VALID), 32'd0);
`ifdef SHIFT_SEQ_PERF_EN
        check("perf_stall", PERF_STALL, 32'd5);
        check("perf_ops", PERF_OPS, 32'd10);
`endif

        // Asynchronous reset in CAP1 of a rotate
        send(3'b011, 32'h8000_0001, 5'd1, 4'hD, "rst_rol");
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        check("midrst_in_ready", 32'(IN_READY), 32'd1);
        check("midrst_out_tag", 32'(OUT_TAG), 32'd0);
        check("midrst_out_z", OUT_Z, 32'd0);
        check("midrst_sh", {SH_X[23:0], SH_S, 1'b0, SH_LEFT, SH_LOG}, 32'd0);
`ifdef SHIFT_SEQ_PERF_EN
        check("midrst_perf_ops", PERF_OPS, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (OUT_VALID) seen++;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        run_op(3'b100, 32'hF000_000F, 5'd4, 4'hE, 32'hFF00_0000, 1'b0, 3, "post_rst_ror");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
